// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and defaults for the common data bus arbiter.
// The ROB/value widths stand in for the core-wide definitions.
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH   = 4;
  localparam int VAL_WIDTH      = 32;
  localparam int CDB_LAB_W      = ROB_ID_WIDTH + 1;
  localparam int CDB_N_SRC      = 2;
  localparam int CDB_N_LANE     = 1;
  localparam int CDB_FIFO_DEPTH = 4;

  // Source id width; at least one bit even with a single source.
  function automatic int src_id_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus.
// Source i transfers on a rising edge when src_valid[i] & src_ready[i] and the bus is enabled
// (rdy_in high, no flush); out_valid lanes are broadcasts with no backpressure.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = CDB_N_SRC,
  parameter int N_LANE = CDB_N_LANE,
  parameter int LAB_W  = CDB_LAB_W,
  parameter int VAL_W  = VAL_WIDTH,
  parameter int SRC_W  = src_id_w(N_SRC)
);

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*LAB_W-1:0]  src_lab;
  logic [N_SRC*VAL_W-1:0]  src_val;
  logic [N_SRC-1:0]        src_ready;
  logic [N_LANE-1:0]       out_valid;
  logic [N_LANE*LAB_W-1:0] out_lab;
  logic [N_LANE*VAL_W-1:0] out_val;
  logic [N_LANE*SRC_W-1:0] out_src;
  logic                    cdb_busy;
  logic                    pending;

  modport master (
    output src_valid, src_lab, src_val,
    input  src_ready, out_valid, out_lab, out_val, out_src, cdb_busy, pending
  );

  modport slave (
    input  src_valid, src_lab, src_val,
    output src_ready, out_valid, out_lab, out_val, out_src, cdb_busy, pending
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; pointers carry one extra wrap bit to tell full from empty.
module cdb_src_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-source, multi-lane common data bus: per-source FIFOs, round-robin multi-grant
// selection starting at rr_ptr, and registered broadcast lanes valid for one cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC      = CDB_N_SRC,
  parameter int N_LANE     = CDB_N_LANE,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int LAB_W      = CDB_LAB_W,
  parameter int VAL_W      = VAL_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             flush,
  cdb_arbiter_if.slave                     bus,
  output logic [src_id_w(N_SRC)-1:0]       dbg_rr_ptr_o
);

  localparam int SRC_W = src_id_w(N_SRC);
  localparam int EW    = LAB_W + VAL_W;

  logic [N_SRC-1:0]        full_w, empty_w, push_w, grant_w;
  logic [EW-1:0]           head_w [N_SRC];
  logic [SRC_W-1:0]        rr_q, rr_d;
  logic                    adv_w;
  logic [N_LANE-1:0]       valid_q;
  logic [N_LANE*LAB_W-1:0] lab_q;
  logic [N_LANE*VAL_W-1:0] val_q;
  logic [N_LANE*SRC_W-1:0] src_q;

  // Flush outranks everything; a stall freezes queues and pointer alike.
  assign adv_w  = rdy_in & ~flush;
  assign push_w = bus.src_valid & ~full_w & {N_SRC{adv_w}};

  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk     (clk),
      .rst_i   (rst_in),
      .flush_i (flush),
      .push_i  (push_w[s]),
      .pop_i   (grant_w[s] & adv_w),
      .din_i   ({bus.src_lab[s*LAB_W +: LAB_W], bus.src_val[s*VAL_W +: VAL_W]}),
      .dout_o  (head_w[s]),
      .full_o  (full_w[s]),
      .empty_o (empty_w[s])
    );
  end

  // First N_LANE non-empty sources in rotated order win; pointer moves past the last winner.
  always_comb begin
    int idx;
    int n_g;
    grant_w = '0;
    rr_d    = rr_q;
    n_g     = 0;
    for (int j = 0; j < N_SRC; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!empty_w[SRC_W'(idx)] && (n_g < N_LANE)) begin
        grant_w[SRC_W'(idx)] = 1'b1;
        n_g = n_g + 1;
        if (idx == N_SRC - 1) rr_d = '0;
        else                  rr_d = SRC_W'(idx + 1);
      end
    end
  end

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    logic [SRC_W-1:0] sel;
    logic             hit;

    // Lane k takes the k-th non-empty source in the same rotated scan.
    always_comb begin
      int idx;
      int rank;
      sel  = '0;
      hit  = 1'b0;
      rank = 0;
      for (int j = 0; j < N_SRC; j++) begin
        idx = int'(rr_q) + j;
        if (idx >= N_SRC) idx = idx - N_SRC;
        if (!empty_w[SRC_W'(idx)]) begin
          if (rank == k) begin
            sel = SRC_W'(idx);
            hit = 1'b1;
          end
          rank = rank + 1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        valid_q[k]                 <= 1'b0;
        lab_q[k*LAB_W +: LAB_W]    <= '0;
        val_q[k*VAL_W +: VAL_W]    <= '0;
        src_q[k*SRC_W +: SRC_W]    <= '0;
      end else if (!adv_w) begin
        valid_q[k] <= 1'b0;
      end else begin
        valid_q[k] <= hit;
        if (hit) begin
          lab_q[k*LAB_W +: LAB_W] <= head_w[sel][EW-1 -: LAB_W];
          val_q[k*VAL_W +: VAL_W] <= head_w[sel][VAL_W-1:0];
          src_q[k*SRC_W +: SRC_W] <= sel;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)      rr_q <= '0;
    else if (flush)  rr_q <= '0;
    else if (rdy_in) rr_q <= rr_d;
  end

  assign bus.src_ready = ~full_w;
  assign bus.out_valid = valid_q;
  assign bus.out_lab   = lab_q;
  assign bus.out_val   = val_q;
  assign bus.out_src   = src_q;
  assign bus.cdb_busy  = |valid_q;
  assign bus.pending   = ~(&empty_w);
  assign dbg_rr_ptr_o  = rr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 2-source/1-lane and a 3-source/2-lane instance checked against
// a queue-based model of the bus rules.
module tb_cdb_arbiter;

  localparam int LW    = 5;
  localparam int VW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(2), .N_LANE(1), .LAB_W(LW), .VAL_W(VW)) bus_a ();
  cdb_arbiter_if #(.N_SRC(3), .N_LANE(2), .LAB_W(LW), .VAL_W(VW)) bus_b ();
  logic       rr_a;
  logic [1:0] rr_b;

  cdb_arbiter #(.N_SRC(2), .N_LANE(1), .FIFO_DEPTH(DEPTH), .LAB_W(LW), .VAL_W(VW)) dut_a (
    .clk(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush), .bus(bus_a), .dbg_rr_ptr_o(rr_a)
  );
  cdb_arbiter #(.N_SRC(3), .N_LANE(2), .FIFO_DEPTH(DEPTH), .LAB_W(LW), .VAL_W(VW)) dut_b (
    .clk(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush), .bus(bus_b), .dbg_rr_ptr_o(rr_b)
  );

  // Stimulus arrays, index [dut][source]
  logic          in_v   [2][3];
  logic [LW-1:0] in_lab [2][3];
  logic [VW-1:0] in_val [2][3];

  assign bus_a.src_valid = {in_v[0][1], in_v[0][0]};
  assign bus_a.src_lab   = {in_lab[0][1], in_lab[0][0]};
  assign bus_a.src_val   = {in_val[0][1], in_val[0][0]};
  assign bus_b.src_valid = {in_v[1][2], in_v[1][1], in_v[1][0]};
  assign bus_b.src_lab   = {in_lab[1][2], in_lab[1][1], in_lab[1][0]};
  assign bus_b.src_val   = {in_val[1][2], in_val[1][1], in_val[1][0]};

  // Observed outputs, index [dut][lane] / [dut][source]
  logic          o_v    [2][2];
  logic [LW-1:0] o_lab  [2][2];
  logic [VW-1:0] o_val  [2][2];
  logic [1:0]    o_src  [2][2];
  logic          o_rdy  [2][3];
  logic          o_busy [2];
  logic          o_pend [2];
  logic [1:0]    o_rr   [2];

  always_comb begin
    o_v[0][0]   = bus_a.out_valid[0];
    o_lab[0][0] = bus_a.out_lab[4:0];
    o_val[0][0] = bus_a.out_val[31:0];
    o_src[0][0] = {1'b0, bus_a.out_src[0]};
    o_v[0][1]   = 1'b0;
    o_lab[0][1] = '0;
    o_val[0][1] = '0;
    o_src[0][1] = '0;
    o_v[1][0]   = bus_b.out_valid[0];
    o_lab[1][0] = bus_b.out_lab[4:0];
    o_val[1][0] = bus_b.out_val[31:0];
    o_src[1][0] = bus_b.out_src[1:0];
    o_v[1][1]   = bus_b.out_valid[1];
    o_lab[1][1] = bus_b.out_lab[9:5];
    o_val[1][1] = bus_b.out_val[63:32];
    o_src[1][1] = bus_b.out_src[3:2];
    o_rdy[0][0] = bus_a.src_ready[0];
    o_rdy[0][1] = bus_a.src_ready[1];
    o_rdy[0][2] = 1'b1;
    o_rdy[1][0] = bus_b.src_ready[0];
    o_rdy[1][1] = bus_b.src_ready[1];
    o_rdy[1][2] = bus_b.src_ready[2];
    o_busy[0]   = bus_a.cdb_busy;
    o_busy[1]   = bus_b.cdb_busy;
    o_pend[0]   = bus_a.pending;
    o_pend[1]   = bus_b.pending;
    o_rr[0]     = {1'b0, rr_a};
    o_rr[1]     = rr_b;
  end

  // Reference model state
  logic [LW+VW-1:0] mq [2][3][$];
  int               m_rr  [2];
  logic             e_vld [2][2];
  logic [LW-1:0]    e_lab [2][2];
  logic [VW-1:0]    e_val [2][2];
  int               e_src [2][2];
  int               ns_cfg [2];
  int               nl_cfg [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) mq[d][s].delete();
      m_rr[d] = 0;
      for (int k = 0; k < 2; k++) e_vld[d][k] = 1'b0;
    end
  endtask

  // One clock edge of the bus as seen from outside: grant, broadcast, then accept offers.
  task automatic model_step(input int d);
    int sizes [3];
    int ng, last, s;
    logic [LW+VW-1:0] ent;
    for (int i = 0; i < 3; i++) sizes[i] = mq[d][i].size();
    for (int k = 0; k < 2; k++) e_vld[d][k] = 1'b0;
    if (flush) begin
      for (int i = 0; i < 3; i++) mq[d][i].delete();
      m_rr[d] = 0;
      return;
    end
    if (!rdy) return;
    ng = 0;
    last = -1;
    for (int j = 0; j < ns_cfg[d]; j++) begin
      s = (m_rr[d] + j) % ns_cfg[d];
      if (sizes[s] > 0 && ng < nl_cfg[d]) begin
        ent = mq[d][s].pop_front();
        e_vld[d][ng] = 1'b1;
        e_lab[d][ng] = ent[LW+VW-1:VW];
        e_val[d][ng] = ent[VW-1:0];
        e_src[d][ng] = s;
        ng++;
        last = s;
      end
    end
    if (last >= 0) m_rr[d] = (last + 1) % ns_cfg[d];
    for (int i = 0; i < ns_cfg[d]; i++)
      if (in_v[d][i] && sizes[i] < DEPTH) mq[d][i].push_back({in_lab[d][i], in_val[d][i]});
  endtask

  task automatic check_all();
    logic any_p, any_v;
    for (int d = 0; d < 2; d++) begin
      any_p = 1'b0;
      any_v = 1'b0;
      for (int k = 0; k < nl_cfg[d]; k++) begin
        chk($sformatf("d%0d_out_valid%0d", d, k), 64'(o_v[d][k]), 64'(e_vld[d][k]));
        any_v |= e_vld[d][k];
        if (e_vld[d][k]) begin
          chk($sformatf("d%0d_out_lab%0d", d, k), 64'(o_lab[d][k]), 64'(e_lab[d][k]));
          chk($sformatf("d%0d_out_val%0d", d, k), 64'(o_val[d][k]), 64'(e_val[d][k]));
          chk($sformatf("d%0d_out_src%0d", d, k), 64'(o_src[d][k]), 64'(e_src[d][k]));
        end
      end
      for (int s = 0; s < ns_cfg[d]; s++) begin
        chk($sformatf("d%0d_src_ready%0d", d, s), 64'(o_rdy[d][s]), 64'(mq[d][s].size() < DEPTH));
        if (mq[d][s].size() > 0) any_p = 1'b1;
      end
      chk($sformatf("d%0d_pending", d), 64'(o_pend[d]), 64'(any_p));
      chk($sformatf("d%0d_cdb_busy", d), 64'(o_busy[d]), 64'(any_v));
      chk($sformatf("d%0d_rr_ptr", d), 64'(o_rr[d]), 64'(m_rr[d]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 3; s++) begin
        in_v[d][s]   = 1'b0;
        in_lab[d][s] = '0;
        in_val[d][s] = '0;
      end
  endtask

  logic [LW-1:0] got [$];
  logic [LW-1:0] exp_q [$];
  logic          saw_full;

  initial begin
    ns_cfg[0] = 2; ns_cfg[1] = 3;
    nl_cfg[0] = 1; nl_cfg[1] = 2;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_src_ready_a", 64'(bus_a.src_ready), 64'd3);
    rst = 1'b0;

    // Single result, one-cycle latency, one-cycle broadcast
    in_v[0][0] = 1'b1; in_lab[0][0] = 5'd5; in_val[0][0] = 32'hAA;
    cycle();
    idle_inputs();
    cycle();
    chk("t1_valid", 64'(o_v[0][0]), 64'd1);
    chk("t1_lab", 64'(o_lab[0][0]), 64'd5);
    chk("t1_val", 64'(o_val[0][0]), 64'hAA);
    chk("t1_src", 64'(o_src[0][0]), 64'd0);
    cycle();
    chk("t1_valid_drop", 64'(o_v[0][0]), 64'd0);

    // Strict alternation from rr_ptr=0 with per-source order kept
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    exp_q = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    got.delete();
    for (int c = 0; c < 12; c++) begin
      in_v[0][0] = (c < 3); in_lab[0][0] = 5'(c + 1);  in_val[0][0] = $urandom;
      in_v[0][1] = (c < 3); in_lab[0][1] = 5'(c + 9);  in_val[0][1] = $urandom;
      cycle();
      if (o_v[0][0]) got.push_back(o_lab[0][0]);
    end
    idle_inputs();
    chk("t2_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(got[i]), 64'(exp_q[i]));

    // Stall blocks enqueue; then src0 fills while src1 shares the single lane
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_v[0][0] = 1'b1; in_lab[0][0] = 5'(c); in_val[0][0] = $urandom;
      cycle();
    end
    chk("t3_no_enq", 64'(o_pend[0]), 64'd0);
    rdy = 1'b1;
    saw_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_v[0][0] = 1'b1; in_lab[0][0] = 5'(c);      in_val[0][0] = $urandom;
      in_v[0][1] = 1'b1; in_lab[0][1] = 5'(16 + c); in_val[0][1] = $urandom;
      cycle();
      if (o_rdy[0][0] === 1'b0) saw_full = 1'b1;
    end
    chk("t3_src0_full_seen", 64'(saw_full), 64'd1);
    idle_inputs();
    for (int c = 0; c < 20; c++) cycle();
    chk("t3_drained", 64'(o_pend[0]), 64'd0);

    // Two lanes, rr_ptr=2: src2 then src0, pointer ends at 1
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_v[1][1] = 1'b1; in_lab[1][1] = 5'd7; in_val[1][1] = 32'h70;
    cycle();
    for (int s = 0; s < 3; s++) begin
      in_v[1][s] = 1'b1; in_lab[1][s] = 5'(20 + s); in_val[1][s] = $urandom;
    end
    cycle();
    chk("t4_pre_rr", 64'(o_rr[1]), 64'd2);
    idle_inputs();
    cycle();
    chk("t4_lane0_src", 64'(o_src[1][0]), 64'd2);
    chk("t4_lane1_src", 64'(o_src[1][1]), 64'd0);
    chk("t4_lane0_lab", 64'(o_lab[1][0]), 64'd22);
    chk("t4_lane1_lab", 64'(o_lab[1][1]), 64'd20);
    chk("t4_rr_next", 64'(o_rr[1]), 64'd1);
    for (int c = 0; c < 4; c++) cycle();

    // Flush beats a concurrent offer
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < ns_cfg[d]; s++) begin
          in_v[d][s] = 1'b1; in_lab[d][s] = 5'($urandom); in_val[d][s] = $urandom;
        end
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle_inputs();
    chk("t5_pending_a", 64'(o_pend[0]), 64'd0);
    chk("t5_pending_b", 64'(o_pend[1]), 64'd0);
    chk("t5_ready_b", 64'(bus_b.src_ready), 64'd7);
    chk("t5_rr_b", 64'(o_rr[1]), 64'd0);
    cycle();
    chk("t5_dropped", 64'(o_v[1][0]), 64'd0);

    // Asynchronous reset in the middle of a burst
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < ns_cfg[d]; s++) begin
          in_v[d][s] = 1'b1; in_lab[d][s] = 5'($urandom); in_val[d][s] = $urandom;
        end
      cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_valid_a", 64'(bus_a.out_valid), 64'd0);
    chk("t6_valid_b", 64'(bus_b.out_valid), 64'd0);
    chk("t6_lab_b", 64'(bus_b.out_lab), 64'd0);
    chk("t6_pending_b", 64'(o_pend[1]), 64'd0);
    chk("t6_ready_b", 64'(bus_b.src_ready), 64'd7);
    check_all();
    cycle();
    rst = 1'b0;
    idle_inputs();
    cycle();

    // Randomized traffic with occasional stalls and flushes
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 29) == 0);
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < ns_cfg[d]; s++) begin
          in_v[d][s]   = ($urandom_range(0, 2) != 0);
          in_lab[d][s] = 5'($urandom);
          in_val[d][s] = $urandom;
        end
      cycle();
    end
    rdy = 1'b1;
    flush = 1'b0;
    idle_inputs();
    for (int c = 0; c < 15; c++) cycle();
    chk("final_idle_a", 64'(o_pend[0]), 64'd0);
    chk("final_idle_b", 64'(o_pend[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
